// File: rtl/img_conv_host_seq_if.sv
// img_conv_pkg / img_conv_host_seq_if
//
// Purpose:
//   img_conv_pkg holds the img_conv_top command opcodes.
//   img_conv_host_seq_if bundles the img_conv_top command port
//   (en/op/din/dout/busy) that the host sequencer drives.
//
// Ports (interface signals):
//   dut_en    1        command strobe, high for one cycle per issue
//   dut_op    opcode_t command opcode, OP_NOP when idle
//   dut_din   8        SET value on issue, pixel data while streaming in
//   dut_dout  8        readback value / output pixel from the core
//   dut_busy  1        core busy flag
//
// Modports:
//   master  host side (drives en/op/din)
//   slave   core side (drives dout/busy)

package img_conv_pkg;
    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_SET_NROWS = 3'd1,
        OP_SET_NCOLS = 3'd2,
        OP_SET_SIGMA = 3'd3,
        OP_IMG_RX    = 3'd4,
        OP_CONV      = 3'd5,
        OP_IMG_TX    = 3'd6
    } opcode_t;
endpackage

interface img_conv_host_seq_if;
    import img_conv_pkg::*;

    logic       dut_en;
    opcode_t    dut_op;
    logic [7:0] dut_din;
    logic [7:0] dut_dout;
    logic       dut_busy;

    modport master (output dut_en, output dut_op, output dut_din,
                    input  dut_dout, input dut_busy);
    modport slave  (input  dut_en, input dut_op, input dut_din,
                    output dut_dout, output dut_busy);
endinterface

// File: rtl/img_conv_host_seq.sv
// img_conv_host_seq
//
// Purpose:
//   Host-side initiator for the img_conv_top command port. One start pulse
//   runs a whole job: SET_NROWS, SET_NCOLS, SET_SIGMA, IMG_RX (pixels in),
//   CONV, IMG_TX (pixels out). Any error ends the job early with done and a
//   sticky err/err_code.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                1-cycle job request, honoured only when idle
//   cfg_nrows/ncols/sigma  job configuration, captured at start
//   in_data/in_valid     pixel source, row-major
//   in_ready             pixel consumed this cycle
//   out_data/out_valid   captured output pixels (no backpressure)
//   seq_busy             job in progress
//   done                 1-cycle pulse at job end
//   err/err_code         sticky error flag and cause
//                        (0 none, 1 readback, 2 timeout, 3 underrun, 4 count)
//   bus                  img_conv_top command port (master modport)
//
// Build option:
//   HOST_READBACK_CHECK_EN  when defined, dut_dout is compared with the
//   value just written the cycle after every SET issue.

module img_conv_host_seq
    import img_conv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            cfg_nrows,
    input  logic [7:0]            cfg_ncols,
    input  logic [2:0]            cfg_sigma,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    output logic                  seq_busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            err_code,
    img_conv_host_seq_if.master   bus
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SET_R   = 4'd1;
    localparam logic [3:0] S_SET_C   = 4'd2;
    localparam logic [3:0] S_SET_S   = 4'd3;
    localparam logic [3:0] S_RX_ISS  = 4'd4;
    localparam logic [3:0] S_RX_WAIT = 4'd5;
    localparam logic [3:0] S_RX_STRM = 4'd6;
    localparam logic [3:0] S_CV_ISS  = 4'd7;
    localparam logic [3:0] S_CV_HI   = 4'd8;
    localparam logic [3:0] S_CV_LO   = 4'd9;
    localparam logic [3:0] S_TX_ISS  = 4'd10;
    localparam logic [3:0] S_TX_WAIT = 4'd11;
    localparam logic [3:0] S_TX_STRM = 4'd12;
    localparam logic [3:0] S_FIN     = 4'd13;

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [3:0]       state, state_nxt;
    logic             set_gap;
    logic [7:0]       nrows_q, ncols_q;
    logic [2:0]       sigma_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] timer;
    logic             err_q;
    logic [2:0]       err_code_q;
    logic [7:0]       out_data_q;
    logic             out_valid_q;

    logic [7:0]       rows_eff, cols_eff;
    logic             tmo;
    logic             fail;
    logic [2:0]       fail_code;
    logic             rb_bad;

    // A zero dimension is treated as 1, the same way the core does.
    assign rows_eff = (cfg_nrows == 8'd0) ? 8'd1 : cfg_nrows;
    assign cols_eff = (cfg_ncols == 8'd0) ? 8'd1 : cfg_ncols;

    // The timer restarts on every state change, so it measures time spent in
    // the current wait state; the last allowed cycle is TIMEOUT_CYCLES-1.
    assign tmo = (int'(timer) >= TIMEOUT_CYCLES - 1);

`ifdef HOST_READBACK_CHECK_EN
    logic [7:0] rb_exp;

    // The core echoes the written value on dout one cycle after a SET.
    always_comb begin
        rb_exp = 8'd0;
        rb_bad = 1'b0;
        case (state)
            S_SET_R: rb_exp = nrows_q;
            S_SET_C: rb_exp = ncols_q;
            S_SET_S: rb_exp = {5'd0, sigma_q};
            default: rb_exp = 8'd0;
        endcase
        if (set_gap && (state == S_SET_R || state == S_SET_C || state == S_SET_S))
            rb_bad = (bus.dut_dout != rb_exp);
    end
`else
    assign rb_bad = 1'b0;
`endif

    // Command port and pixel-source handshake are decoded from the state so
    // dut_en can only ever be a single-cycle strobe.
    always_comb begin
        bus.dut_en  = 1'b0;
        bus.dut_op  = OP_NOP;
        bus.dut_din = 8'd0;
        in_ready    = 1'b0;
        case (state)
            S_SET_R: if (!set_gap) begin
                bus.dut_en  = 1'b1;
                bus.dut_op  = OP_SET_NROWS;
                bus.dut_din = nrows_q;
            end
            S_SET_C: if (!set_gap) begin
                bus.dut_en  = 1'b1;
                bus.dut_op  = OP_SET_NCOLS;
                bus.dut_din = ncols_q;
            end
            S_SET_S: if (!set_gap) begin
                bus.dut_en  = 1'b1;
                bus.dut_op  = OP_SET_SIGMA;
                bus.dut_din = {5'd0, sigma_q};
            end
            S_RX_ISS: begin
                bus.dut_en = 1'b1;
                bus.dut_op = OP_IMG_RX;
            end
            S_RX_STRM: if (bus.dut_busy) begin
                in_ready    = 1'b1;
                bus.dut_din = in_data;
            end
            S_CV_ISS: begin
                bus.dut_en = 1'b1;
                bus.dut_op = OP_CONV;
            end
            S_TX_ISS: begin
                bus.dut_en = 1'b1;
                bus.dut_op = OP_IMG_TX;
            end
            default: ;
        endcase
    end

    // Next-state logic. Every error routes straight to FIN, which is why the
    // first error of a job is also the only one recorded.
    always_comb begin
        state_nxt = state;
        fail      = 1'b0;
        fail_code = 3'd0;
        case (state)
            S_IDLE:    if (start) state_nxt = S_SET_R;
            S_SET_R:   if (set_gap) begin
                           if (rb_bad) begin fail = 1'b1; fail_code = 3'd1; end
                           else state_nxt = S_SET_C;
                       end
            S_SET_C:   if (set_gap) begin
                           if (rb_bad) begin fail = 1'b1; fail_code = 3'd1; end
                           else state_nxt = S_SET_S;
                       end
            S_SET_S:   if (set_gap) begin
                           if (rb_bad) begin fail = 1'b1; fail_code = 3'd1; end
                           else state_nxt = S_RX_ISS;
                       end
            S_RX_ISS:  state_nxt = S_RX_WAIT;
            S_RX_WAIT: if (bus.dut_busy) state_nxt = S_RX_STRM;
                       else if (tmo) begin fail = 1'b1; fail_code = 3'd2; end
            S_RX_STRM: if (bus.dut_busy) begin
                           if (!in_valid) begin fail = 1'b1; fail_code = 3'd3; end
                       end else if (cnt != n_q) begin
                           fail = 1'b1; fail_code = 3'd4;
                       end else begin
                           state_nxt = S_CV_ISS;
                       end
            S_CV_ISS:  state_nxt = S_CV_HI;
            S_CV_HI:   if (bus.dut_busy) state_nxt = S_CV_LO;
                       else if (tmo) begin fail = 1'b1; fail_code = 3'd2; end
            S_CV_LO:   if (!bus.dut_busy) state_nxt = S_TX_ISS;
                       else if (tmo) begin fail = 1'b1; fail_code = 3'd2; end
            S_TX_ISS:  state_nxt = S_TX_WAIT;
            S_TX_WAIT: if (bus.dut_busy) state_nxt = S_TX_STRM;
                       else if (tmo) begin fail = 1'b1; fail_code = 3'd2; end
            S_TX_STRM: if (!bus.dut_busy) begin
                           if (cnt != n_q) begin fail = 1'b1; fail_code = 3'd4; end
                           else state_nxt = S_FIN;
                       end
            S_FIN:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (fail) state_nxt = S_FIN;
    end

    // State, counters and captured job parameters. The pixel counter
    // saturates so an overlong stream can never wrap back onto N.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            set_gap     <= 1'b0;
            nrows_q     <= 8'd0;
            ncols_q     <= 8'd0;
            sigma_q     <= 3'd0;
            n_q         <= '0;
            cnt         <= '0;
            timer       <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            set_gap <= (state_nxt == state) ? ~set_gap : 1'b0;

            if (state_nxt != state) timer <= '0;
            else                    timer <= timer + TMR_W'(1);

            if (state_nxt != state)
                cnt <= '0;
            else if ((state == S_RX_STRM || state == S_TX_STRM) && bus.dut_busy && cnt != '1)
                cnt <= cnt + CNT_W'(1);

            if (state == S_IDLE && start) begin
                nrows_q    <= rows_eff;
                ncols_q    <= cols_eff;
                sigma_q    <= cfg_sigma;
                n_q        <= CNT_W'(rows_eff) * CNT_W'(cols_eff);
                err_q      <= 1'b0;
                err_code_q <= 3'd0;
            end

            if (fail) begin
                err_q      <= 1'b1;
                err_code_q <= fail_code;
            end

            out_valid_q <= (state == S_TX_STRM) && bus.dut_busy;
            if ((state == S_TX_STRM) && bus.dut_busy)
                out_data_q <= bus.dut_dout;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign seq_busy  = (state != S_IDLE);
    assign done      = (state == S_FIN);
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_img_conv_host_seq.sv
// tb_img_conv_host_seq
//
// Purpose:
//   Self-checking bench for img_conv_host_seq. A behavioural img_conv_top
//   model answers the command port; expected issues, output pixels and job
//   results are queued when a job starts and a negedge monitor pops and
//   compares them as the sequencer presents them.

module tb_img_conv_host_seq;
    import img_conv_pkg::*;

    localparam int TMO = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cfg_nrows, cfg_ncols;
    logic [2:0] cfg_sigma;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       seq_busy;
    logic       done;
    logic       err;
    logic [2:0] err_code;

    img_conv_host_seq_if bus ();

    img_conv_host_seq #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_nrows (cfg_nrows),
        .cfg_ncols (cfg_ncols),
        .cfg_sigma (cfg_sigma),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .seq_busy  (seq_busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] din;
    } issue_t;

    issue_t     expIssue[$];
    logic [7:0] expPix[$];
    logic [3:0] expDone[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int doneCnt = 0;
    int rdyCnt  = 0;
    int convCyc = 0;
    int doneCyc = 0;
    int srcIdx  = 0;
    int dropAt  = 1000;
    int pixSeed = 0;
    bit rbBad   = 1'b0;
    bit noConv  = 1'b0;
    bit chkIdleNext = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pixAt(input int i, input int seed);
        return 8'(i * 13 + seed);
    endfunction

    // Records one comparison and reports it when it does not hold.
    task automatic checkOutput(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Behavioural img_conv_top: echoes SET values, takes N pixels after a
    // one-cycle busy lead-in, runs a short CONV, returns pixel+1 on TX.
    logic [7:0] mem [256];
    logic [7:0] mRows = 8'd1, mCols = 8'd1;
    logic [1:0] mMode;
    int         mk;
    int         mN;

    always_comb mN = int'(mRows) * int'(mCols);

    always @(posedge clk) begin
        if (rst) begin
            bus.dut_busy <= 1'b0;
            bus.dut_dout <= 8'd0;
            mMode        <= 2'd0;
            mk           <= 0;
        end else if (bus.dut_en) begin
            case (bus.dut_op)
                OP_SET_NROWS: begin
                    mRows        <= (bus.dut_din == 8'd0) ? 8'd1 : bus.dut_din;
                    bus.dut_dout <= rbBad ? 8'd7 : bus.dut_din;
                end
                OP_SET_NCOLS: begin
                    mCols        <= (bus.dut_din == 8'd0) ? 8'd1 : bus.dut_din;
                    bus.dut_dout <= bus.dut_din;
                end
                OP_SET_SIGMA: bus.dut_dout <= bus.dut_din;
                OP_IMG_RX: begin
                    mMode <= 2'd1; bus.dut_busy <= 1'b1; mk <= 0;
                end
                OP_CONV: if (!noConv) begin
                    mMode <= 2'd2; bus.dut_busy <= 1'b1; mk <= 0;
                end
                OP_IMG_TX: begin
                    mMode <= 2'd3; bus.dut_busy <= 1'b1; mk <= 0;
                end
                default: ;
            endcase
        end else begin
            case (mMode)
                2'd1: begin
                    if (mk != 0) begin
                        mem[(mk - 1) & 255] <= bus.dut_din;
                        if (mk == mN) begin bus.dut_busy <= 1'b0; mMode <= 2'd0; end
                    end
                    mk <= mk + 1;
                end
                2'd2: begin
                    if (mk == 3) begin bus.dut_busy <= 1'b0; mMode <= 2'd0; end
                    mk <= mk + 1;
                end
                2'd3: begin
                    if (mk == mN) begin
                        bus.dut_busy <= 1'b0; mMode <= 2'd0;
                    end else begin
                        bus.dut_dout <= mem[mk & 255] + 8'd1;
                        mk <= mk + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel source: presents pixel srcIdx, advances when it is consumed.
    initial begin
        in_data  = 8'd0;
        in_valid = 1'b0;
        forever begin
            @(negedge clk);
            in_data  = pixAt(srcIdx, pixSeed);
            in_valid = (srcIdx < dropAt);
            if (in_ready) srcIdx++;
        end
    end

    // Monitor: pops the scoreboard whenever the sequencer presents something.
    issue_t     monE;
    logic [7:0] monP;
    logic [3:0] monD;

    always @(negedge clk) begin
        if (!rst) begin
            if (chkIdleNext) begin
                checkOutput("seq_busy_after_done", int'(seq_busy), 0);
                chkIdleNext = 1'b0;
            end
            if (in_ready) rdyCnt++;
            if (bus.dut_en) begin
                if (bus.dut_op == OP_CONV) convCyc = cyc;
                if (expIssue.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL issue_extra actual_op=%0d required=none", int'(bus.dut_op));
                end else begin
                    monE = expIssue.pop_front();
                    checkOutput("issue_op", int'(bus.dut_op), int'(monE.op));
                    if (monE.op inside {3'd1, 3'd2, 3'd3})
                        checkOutput("issue_din", int'(bus.dut_din), int'(monE.din));
                end
            end
            if (out_valid) begin
                if (expPix.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL pix_extra actual=%0d required=none", out_data);
                end else begin
                    monP = expPix.pop_front();
                    checkOutput("out_data", int'(out_data), int'(monP));
                end
            end
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
                chkIdleNext = 1'b1;
                if (expDone.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL done_extra actual=%0d required=none", {err, err_code});
                end else begin
                    monD = expDone.pop_front();
                    checkOutput("done_err", int'({err, err_code}), int'(monD));
                end
            end
        end
    end

    task automatic pushIssue(input opcode_t op, input logic [7:0] din);
        issue_t e;
        e.op  = op;
        e.din = din;
        expIssue.push_back(e);
    endtask

    task automatic waitModelIdle();
        for (int i = 0; i < 3000 && bus.dut_busy; i++) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkQueuesEmpty(input string tag);
        checkOutput({tag, "_issues_left"}, expIssue.size(), 0);
        checkOutput({tag, "_pix_left"}, expPix.size(), 0);
        checkOutput({tag, "_done_left"}, expDone.size(), 0);
        expIssue.delete();
        expPix.delete();
        expDone.delete();
    endtask

    // Queues the expected outcome of one job, starts it and waits for done.
    // nIss: how many of the six issues are expected; pixOut: TX data expected.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] c, input logic [2:0] s,
                                 input int drop, input bit rbb, input bit ncv, input int seed,
                                 input int nIss, input bit pixOut, input logic [3:0] res);
        logic [7:0] er, ec;
        int n, d0;
        bit seen;
        er = (r == 8'd0) ? 8'd1 : r;
        ec = (c == 8'd0) ? 8'd1 : c;
        n  = int'(er) * int'(ec);
        rbBad = rbb; noConv = ncv; dropAt = drop; pixSeed = seed;
        srcIdx = 0; rdyCnt = 0;
        if (nIss > 0) pushIssue(OP_SET_NROWS, er);
        if (nIss > 1) pushIssue(OP_SET_NCOLS, ec);
        if (nIss > 2) pushIssue(OP_SET_SIGMA, {5'd0, s});
        if (nIss > 3) pushIssue(OP_IMG_RX, 8'd0);
        if (nIss > 4) pushIssue(OP_CONV, 8'd0);
        if (nIss > 5) pushIssue(OP_IMG_TX, 8'd0);
        if (pixOut) for (int i = 0; i < n; i++) expPix.push_back(pixAt(i, seed) + 8'd1);
        expDone.push_back(res);
        d0 = doneCnt;
        @(negedge clk);
        cfg_nrows = r; cfg_ncols = c; cfg_sigma = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(posedge clk);
            if (doneCnt != d0) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("[TB] FAIL job_timeout actual=no_done required=done");
        end
        @(negedge clk);
        @(negedge clk);
        waitModelIdle();
    endtask

    initial begin
        int d0;
        bit hit;
        rst = 1'b1; start = 1'b0;
        cfg_nrows = 8'd0; cfg_ncols = 8'd0; cfg_sigma = 3'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_dut_en", int'(bus.dut_en), 0);
        checkOutput("rst_dut_op", int'(bus.dut_op), int'(OP_NOP));
        checkOutput("rst_seq_busy", int'(seq_busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_err", int'({err, err_code}), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] job 1: 8x8 sigma 2");
        applyStimulus(8'd8, 8'd8, 3'd2, 1000, 1'b0, 1'b0, 5, 6, 1'b1, 4'h0);
        checkOutput("t1_in_ready_count", rdyCnt, 64);
        checkQueuesEmpty("t1");

        $display("[TB] job 2: zero rows, 3 cols");
        applyStimulus(8'd0, 8'd3, 3'd1, 1000, 1'b0, 1'b0, 40, 6, 1'b1, 4'h0);
        checkOutput("t2_in_ready_count", rdyCnt, 3);
        checkQueuesEmpty("t2");

        $display("[TB] job 3: underrun at pixel 10 of 16");
        applyStimulus(8'd4, 8'd4, 3'd3, 10, 1'b0, 1'b0, 77, 4, 1'b0, 4'hB);
        checkQueuesEmpty("t3");

        $display("[TB] job 4: core never busy after CONV");
        applyStimulus(8'd2, 8'd2, 3'd0, 1000, 1'b0, 1'b1, 3, 5, 1'b0, 4'hA);
        checkOutput("t4_timeout_window",
                    int'((doneCyc - convCyc) >= TMO && (doneCyc - convCyc) <= TMO + 2), 1);
        checkQueuesEmpty("t4");

        $display("[TB] job 5: bad nrows readback");
`ifdef HOST_READBACK_CHECK_EN
        applyStimulus(8'd8, 8'd2, 3'd4, 1000, 1'b1, 1'b0, 11, 1, 1'b0, 4'h9);
`else
        applyStimulus(8'd8, 8'd2, 3'd4, 1000, 1'b1, 1'b0, 11, 6, 1'b1, 4'h0);
`endif
        checkQueuesEmpty("t5");
        rbBad = 1'b0;

        $display("[TB] job 6: reset during pixel stream");
        rbBad = 1'b0; noConv = 1'b0; dropAt = 1000; pixSeed = 9;
        srcIdx = 0; rdyCnt = 0;
        pushIssue(OP_SET_NROWS, 8'd4);
        pushIssue(OP_SET_NCOLS, 8'd4);
        pushIssue(OP_SET_SIGMA, 8'd1);
        pushIssue(OP_IMG_RX, 8'd0);
        d0 = doneCnt;
        @(negedge clk);
        cfg_nrows = 8'd4; cfg_ncols = 8'd4; cfg_sigma = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (rdyCnt >= 5) hit = 1'b1;
        end
        checkOutput("t6_reached_stream", int'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_dut_en", int'(bus.dut_en), 0);
        checkOutput("t6_seq_busy", int'(seq_busy), 0);
        checkOutput("t6_in_ready", int'(in_ready), 0);
        checkOutput("t6_done", int'(done), 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("t6_no_done", doneCnt, d0);
        checkQueuesEmpty("t6");

        $display("[TB] job 7: clean job after reset, 2x5 sigma 7");
        applyStimulus(8'd2, 8'd5, 3'd7, 1000, 1'b0, 1'b0, 200, 6, 1'b1, 4'h0);
        checkOutput("t7_in_ready_count", rdyCnt, 10);
        checkQueuesEmpty("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
